// File: rtl/writeback_stage.sv
// Dual-lane MEM/WB register and writeback formatter feeding the
// dual-write-port register file; also keeps a retired-lane counter.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   wb_stall, wb_flush    either one loads a bubble into both lanes
//   mem_*_1 / mem_*_2     per-lane memory-stage results
//   reg_w_*_1 / _2        registered register-file write ports
//   wb_pc_1 / wb_pc_2     PC of the lane in WB, 0 for a bubble
//   retire_count          valid lanes retired since reset (wraps)
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_stall,
  input  logic             wb_flush,
  input  logic             mem_valid_1,
  input  logic             mem_valid_2,
  input  logic             mem_w_en_1,
  input  logic             mem_w_en_2,
  input  logic [4:0]       mem_w_addr_1,
  input  logic [4:0]       mem_w_addr_2,
  input  logic [31:0]      mem_alu_data_1,
  input  logic [31:0]      mem_alu_data_2,
  input  logic [31:0]      mem_load_data_1,
  input  logic [31:0]      mem_load_data_2,
  input  logic [2:0]       mem_load_type_1,
  input  logic [2:0]       mem_load_type_2,
  input  logic [1:0]       mem_byte_off_1,
  input  logic [1:0]       mem_byte_off_2,
  input  logic [31:0]      mem_pc_1,
  input  logic [31:0]      mem_pc_2,
  output logic             reg_w_en_1,
  output logic             reg_w_en_2,
  output logic [4:0]       reg_w_addr_1,
  output logic [4:0]       reg_w_addr_2,
  output logic [31:0]      reg_w_data_1,
  output logic [31:0]      reg_w_data_2,
  output logic [31:0]      wb_pc_1,
  output logic [31:0]      wb_pc_2,
  output logic [CNT_W-1:0] retire_count
);

  typedef struct packed {
    logic        valid;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } lane_t;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  function automatic logic [31:0] fmt(
    input logic [2:0]  lt,
    input logic [1:0]  off,
    input logic [31:0] ld,
    input logic [31:0] alu
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = ld[{off, 3'b000} +: 8];
    // off[0] is ignored for halfwords
    h = off[1] ? ld[31:16] : ld[15:0];
    unique case (lt)
      LT_LW:   r = ld;
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'd0, b};
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'd0, h};
      default: r = alu;
    endcase
    return r;
  endfunction

  // An invalid lane is a full bubble so wb_pc reads 0.
  function automatic lane_t mk(
    input logic        v,
    input logic        we,
    input logic [4:0]  a,
    input logic [31:0] d,
    input logic [31:0] pc
  );
    lane_t l;
    l = '0;
    if (v) begin
      l.valid = 1'b1;
      l.en    = we & (a != 5'd0);
      l.addr  = a;
      l.data  = d;
      l.pc    = pc;
    end
    return l;
  endfunction

  lane_t q1, q2;
  lane_t n1, n2;
  logic [CNT_W-1:0] inc;

  always_comb begin
    n1 = mk(mem_valid_1, mem_w_en_1, mem_w_addr_1,
            fmt(mem_load_type_1, mem_byte_off_1,
                mem_load_data_1, mem_alu_data_1),
            mem_pc_1);
    n2 = mk(mem_valid_2, mem_w_en_2, mem_w_addr_2,
            fmt(mem_load_type_2, mem_byte_off_2,
                mem_load_data_2, mem_alu_data_2),
            mem_pc_2);
    if (wb_stall || wb_flush) begin
      n1 = '0;
      n2 = '0;
    end
    // Younger lane 2 wins a same-register write.
    if (n1.en && n2.en && (n1.addr == n2.addr))
      n1.en = 1'b0;
    inc = CNT_W'(n1.valid) + CNT_W'(n2.valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1           <= '0;
      q2           <= '0;
      retire_count <= '0;
    end else begin
      q1           <= n1;
      q2           <= n2;
      retire_count <= retire_count + inc;
    end
  end

  assign reg_w_en_1   = q1.en;
  assign reg_w_en_2   = q2.en;
  assign reg_w_addr_1 = q1.addr;
  assign reg_w_addr_2 = q2.addr;
  assign reg_w_data_1 = q1.data;
  assign reg_w_data_2 = q2.data;
  assign wb_pc_1      = q1.pc;
  assign wb_pc_2      = q2.pc;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: driver pushes expected
// results, a negedge monitor pops and compares.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wb_stall = 1'b0;
  logic wb_flush = 1'b0;
  logic v1 = 0, v2 = 0, we1 = 0, we2 = 0;
  logic [4:0] a1 = 0, a2 = 0;
  logic [31:0] alu1 = 0, alu2 = 0, ld1 = 0, ld2 = 0;
  logic [2:0] lt1 = 3'd5, lt2 = 3'd5;
  logic [1:0] off1 = 0, off2 = 0;
  logic [31:0] pc1 = 0, pc2 = 0;

  logic en1, en2, xen1, xen2;
  logic [4:0] ra1, ra2, xra1, xra2;
  logic [31:0] rd1, rd2, xrd1, xrd2;
  logic [31:0] wp1, wp2, xwp1, xwp2;
  logic [31:0] cnt;
  logic [3:0] cnt4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_stage #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .mem_valid_1(v1), .mem_valid_2(v2),
    .mem_w_en_1(we1), .mem_w_en_2(we2),
    .mem_w_addr_1(a1), .mem_w_addr_2(a2),
    .mem_alu_data_1(alu1), .mem_alu_data_2(alu2),
    .mem_load_data_1(ld1), .mem_load_data_2(ld2),
    .mem_load_type_1(lt1), .mem_load_type_2(lt2),
    .mem_byte_off_1(off1), .mem_byte_off_2(off2),
    .mem_pc_1(pc1), .mem_pc_2(pc2),
    .reg_w_en_1(en1), .reg_w_en_2(en2),
    .reg_w_addr_1(ra1), .reg_w_addr_2(ra2),
    .reg_w_data_1(rd1), .reg_w_data_2(rd2),
    .wb_pc_1(wp1), .wb_pc_2(wp2),
    .retire_count(cnt)
  );

  writeback_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .mem_valid_1(v1), .mem_valid_2(v2),
    .mem_w_en_1(we1), .mem_w_en_2(we2),
    .mem_w_addr_1(a1), .mem_w_addr_2(a2),
    .mem_alu_data_1(alu1), .mem_alu_data_2(alu2),
    .mem_load_data_1(ld1), .mem_load_data_2(ld2),
    .mem_load_type_1(lt1), .mem_load_type_2(lt2),
    .mem_byte_off_1(off1), .mem_byte_off_2(off2),
    .mem_pc_1(pc1), .mem_pc_2(pc2),
    .reg_w_en_1(xen1), .reg_w_en_2(xen2),
    .reg_w_addr_1(xra1), .reg_w_addr_2(xra2),
    .reg_w_data_1(xrd1), .reg_w_data_2(xrd2),
    .wb_pc_1(xwp1), .wb_pc_2(xwp2),
    .retire_count(cnt4)
  );

  typedef struct packed {
    logic v, we;
    logic [4:0] a;
    logic [31:0] alu, ld;
    logic [2:0] lt;
    logic [1:0] off;
    logic [31:0] pc;
  } in_t;

  typedef struct packed {
    logic en;
    logic [4:0] a;
    logic [31:0] d, pc;
  } out_t;

  typedef struct packed {
    out_t l1, l2;
    logic [31:0] c;
    logic [3:0] c4;
  } exp_t;

  exp_t q[$];
  logic [31:0] exp_cnt = 0;
  localparam out_t BUB = '0;

  function automatic in_t li(
    logic v, logic we, logic [4:0] a, logic [31:0] alu,
    logic [31:0] ld, logic [2:0] lt, logic [1:0] off,
    logic [31:0] pc);
    in_t r;
    r = '{v, we, a, alu, ld, lt, off, pc};
    return r;
  endfunction

  function automatic out_t lo(
    logic en, logic [4:0] a, logic [31:0] d, logic [31:0] pc);
    out_t r;
    r = '{en, a, d, pc};
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%08h want=%08h", nm, act, exp);
    end
  endtask

  task automatic apply(in_t x, in_t y, logic st, logic fl);
    {v1, we1, a1, alu1, ld1, lt1, off1, pc1} = x;
    {v2, we2, a2, alu2, ld2, lt2, off2, pc2} = y;
    wb_stall = st;
    wb_flush = fl;
  endtask

  task automatic step(out_t e1, out_t e2, int inc);
    exp_t e;
    @(posedge clk);
    exp_cnt = exp_cnt + 32'(inc);
    e.l1 = e1;
    e.l2 = e2;
    e.c = exp_cnt;
    e.c4 = exp_cnt[3:0];
    q.push_back(e);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_en"}, {30'd0, en1, en2}, 32'd0);
    chk({tag, "_addr"}, {22'd0, ra1, ra2}, 32'd0);
    chk({tag, "_data1"}, rd1, 32'd0);
    chk({tag, "_data2"}, rd2, 32'd0);
    chk({tag, "_pc1"}, wp1, 32'd0);
    chk({tag, "_pc2"}, wp2, 32'd0);
    chk({tag, "_cnt"}, cnt, 32'd0);
    chk({tag, "_cnt4"}, {28'd0, cnt4}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("en1", {31'd0, en1}, {31'd0, e.l1.en});
      chk("addr1", {27'd0, ra1}, {27'd0, e.l1.a});
      chk("data1", rd1, e.l1.d);
      chk("pc1", wp1, e.l1.pc);
      chk("en2", {31'd0, en2}, {31'd0, e.l2.en});
      chk("addr2", {27'd0, ra2}, {27'd0, e.l2.a});
      chk("data2", rd2, e.l2.d);
      chk("pc2", wp2, e.l2.pc);
      chk("retire", cnt, e.c);
      chk("retire4", {28'd0, cnt4}, {28'd0, e.c4});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  localparam logic [31:0] LD = 32'h80FF7F01;

  in_t i1, i2, z;

  initial begin
    z = '0;
    z.lt = 3'd5;
    apply(z, z, 0, 0);
    #12;
    chk_zero("rst_init");

    @(negedge clk);
    reset = 1'b1;
    apply(li(1, 1, 5, 32'h1234, 0, 5, 0, 32'h100), z, 0, 0);
    step(lo(1, 5, 32'h1234, 32'h100), BUB, 1);

    // loads on lane 1
    apply(li(1, 1, 3, 0, LD, 1, 2, 32'h200), z, 0, 0);
    step(lo(1, 3, 32'hFFFFFFFF, 32'h200), BUB, 1);
    apply(li(1, 1, 3, 0, LD, 2, 3, 32'h204), z, 0, 0);
    step(lo(1, 3, 32'h00000080, 32'h204), BUB, 1);
    apply(li(1, 1, 3, 0, LD, 3, 2, 32'h208), z, 0, 0);
    step(lo(1, 3, 32'hFFFF80FF, 32'h208), BUB, 1);
    apply(li(1, 1, 3, 0, LD, 4, 0, 32'h20C), z, 0, 0);
    step(lo(1, 3, 32'h00007F01, 32'h20C), BUB, 1);
    apply(li(1, 1, 3, 0, LD, 0, 3, 32'h210), z, 0, 0);
    step(lo(1, 3, 32'h80FF7F01, 32'h210), BUB, 1);
    apply(li(1, 1, 3, 0, LD, 1, 0, 32'h214), z, 0, 0);
    step(lo(1, 3, 32'h00000001, 32'h214), BUB, 1);
    apply(li(1, 1, 3, 0, LD, 3, 3, 32'h218), z, 0, 0);
    step(lo(1, 3, 32'hFFFF80FF, 32'h218), BUB, 1);
    // lane 2 load
    apply(z, li(1, 1, 4, 0, LD, 2, 1, 32'h21C), 0, 0);
    step(BUB, lo(1, 4, 32'h0000007F, 32'h21C), 1);

    // same-destination conflict
    i1 = li(1, 1, 9, 32'h11, 0, 5, 0, 32'h300);
    i2 = li(1, 1, 9, 32'h22, 0, 5, 0, 32'h304);
    apply(i1, i2, 0, 0);
    step(lo(0, 9, 32'h11, 32'h300),
         lo(1, 9, 32'h22, 32'h304), 2);
    i1.a = 0;
    i2.a = 0;
    apply(i1, i2, 0, 0);
    step(lo(0, 0, 32'h11, 32'h300),
         lo(0, 0, 32'h22, 32'h304), 2);
    // distinct destinations both write
    i1.a = 7;
    i2.a = 8;
    apply(i1, i2, 0, 0);
    step(lo(1, 7, 32'h11, 32'h300),
         lo(1, 8, 32'h22, 32'h304), 2);

    // stall then flush
    i1 = li(1, 1, 10, 32'hA1, 0, 5, 0, 32'h400);
    i2 = li(1, 1, 11, 32'hA2, 0, 5, 0, 32'h404);
    for (int k = 0; k < 3; k++) begin
      apply(i1, i2, 1, 0);
      step(BUB, BUB, 0);
    end
    apply(i1, i2, 0, 0);
    step(lo(1, 10, 32'hA1, 32'h400),
         lo(1, 11, 32'hA2, 32'h404), 2);
    for (int k = 0; k < 3; k++) begin
      apply(i1, i2, 0, 1);
      step(BUB, BUB, 0);
    end
    apply(i1, i2, 1, 1);
    step(BUB, BUB, 0);
    apply(i1, i2, 0, 0);
    step(lo(1, 10, 32'hA1, 32'h400),
         lo(1, 11, 32'hA2, 32'h404), 2);

    // lane 2 only
    apply(li(0, 1, 6, 32'h55, 0, 5, 0, 32'h500),
          li(1, 1, 31, 32'hDEADBEEF, 0, 5, 0, 32'h504),
          0, 0);
    step(BUB, lo(1, 31, 32'hDEADBEEF, 32'h504), 1);
    // valid lane with w_en=0 still retires
    apply(li(1, 0, 6, 32'h66, 0, 5, 0, 32'h508), z, 0, 0);
    step(lo(0, 6, 32'h66, 32'h508), BUB, 1);

    // async reset mid-cycle with lanes in flight
    apply(i1, i2, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 0;

    // counter wrap on the 4-bit instance: 15 then +2
    for (int k = 0; k < 7; k++) begin
      apply(i1, i2, 0, 0);
      step(lo(1, 10, 32'hA1, 32'h400),
           lo(1, 11, 32'hA2, 32'h404), 2);
    end
    apply(i1, z, 0, 0);
    step(lo(1, 10, 32'hA1, 32'h400), BUB, 1);
    apply(i1, i2, 0, 0);
    step(lo(1, 10, 32'hA1, 32'h400),
         lo(1, 11, 32'hA2, 32'h404), 2);
    @(negedge clk);
    #1;
    chk("wrap4", {28'd0, cnt4}, 32'd1);
    chk("wrap32", cnt, 32'd17);
    apply(z, z, 0, 0);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
